// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: raw encoder channels and control strobes in,
// step/direction/position/error out.
interface quad_decoder_if #(
  parameter int N = 4
);
  logic         enc_a;
  logic         enc_b;
  logic         clr_pos;
  logic         err_clr;
  logic         step;
  logic         dir;
  logic [N-1:0] pos;
  logic         err;

  modport master (
    output enc_a, enc_b, clr_pos, err_clr,
    input  step, dir, pos, err
  );

  modport slave (
    input  enc_a, enc_b, clr_pos, err_clr,
    output step, dir, pos, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronize, glitch-filter and decode A/B into
// a step strobe, direction (1 = down) and a wrapping N-bit position count.
module quad_decoder #(
  parameter int N    = 4,
  parameter int FILT = 4
) (
  input logic          clk,
  input logic          rst,
  quad_decoder_if.slave bus
);

  localparam int             CW       = $clog2(FILT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

  localparam logic [1:0] MV_NONE = 2'd0;
  localparam logic [1:0] MV_UP   = 2'd1;
  localparam logic [1:0] MV_DN   = 2'd2;
  localparam logic [1:0] MV_ERR  = 2'd3;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state;
  logic [1:0]    init_cnt;
  logic          sa1, sa2, sb1, sb2;
  logic          fa, fb;
  logic [CW-1:0] ca, cb;
  logic [1:0]    prev;
  logic [1:0]    mv;
  logic          step_r, dir_r, err_r;
  logic [N-1:0]  pos_r;

  // A level is accepted only after it differs from the filtered level on
  // FILT consecutive edges; returns {new level, new count}.
  function automatic logic [CW:0] filt_next(input logic s, input logic f,
                                            input logic [CW-1:0] c);
    if (s == f)        return {f, {CW{1'b0}}};
    if (c == CNT_LAST) return {s, {CW{1'b0}}};
    return {f, c + CW'(1)};
  endfunction

  function automatic logic [1:0] decode(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return MV_UP;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return MV_DN;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: return MV_ERR;
      default:                                return MV_NONE;
    endcase
  endfunction

  assign mv = decode(prev, {fa, fb});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= 2'd0;
      sa1      <= 1'b0;
      sa2      <= 1'b0;
      sb1      <= 1'b0;
      sb2      <= 1'b0;
      fa       <= 1'b0;
      fb       <= 1'b0;
      ca       <= '0;
      cb       <= '0;
      prev     <= 2'b00;
      step_r   <= 1'b0;
      dir_r    <= 1'b0;
      err_r    <= 1'b0;
      pos_r    <= '0;
    end else begin
      // Stage: two-flop synchronizer
      sa1    <= bus.enc_a;
      sa2    <= sa1;
      sb1    <= bus.enc_b;
      sb2    <= sb1;
      step_r <= 1'b0;
      case (state)
        S_INIT: begin
          // sa2 holds a real input sample only after two post-reset edges.
          if (init_cnt == 2'd2) begin
            fa    <= sa2;
            fb    <= sb2;
            ca    <= '0;
            cb    <= '0;
            prev  <= {sa2, sb2};
            state <= S_RUN;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        S_RUN: begin
          // Stage: glitch filter, then decode against the previous filtered pair
          {fa, ca} <= filt_next(sa2, fa, ca);
          {fb, cb} <= filt_next(sb2, fb, cb);
          prev     <= {fa, fb};
          if (mv == MV_UP || mv == MV_DN) begin
            step_r <= 1'b1;
            dir_r  <= (mv == MV_DN);
          end
          if (bus.clr_pos)       pos_r <= '0;
          else if (mv == MV_UP)  pos_r <= pos_r + N'(1);
          else if (mv == MV_DN)  pos_r <= pos_r - N'(1);
          if (mv == MV_ERR)      err_r <= 1'b1;
          else if (bus.err_clr)  err_r <= 1'b0;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.step = step_r;
  assign bus.dir  = dir_r;
  assign bus.pos  = pos_r;
  assign bus.err  = err_r;

endmodule
